timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped countdown timer that acts as a responder on the CPU data-memory bus. The core issues loads and stores; this block decodes the addresses in its window and returns read data combinationally in the same cycle. It counts clock cycles down from a programmed preset. On expiry it raises an interrupt request, either once (one-shot) or periodically (auto-reload). It sits beside the data memory, sharing the address, write-data and write-enable lines; the system read mux selects its `ReadData` on an address hit.

## Interface
- `BASE_ADDR`, default `32'h0000_7F00`: base of the 16-byte register window; bits [3:0] must be 0.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset. Asserted (0) clears all state immediately.
- `Addr` in 32: byte address from the CPU ALU result. Bits [1:0] are ignored.
- `WriteEnable` in 1: store strobe from the controller.
- `WriteData` in 32: store data from the register file's second read port.
- `ReadData` out 32: combinational read data.
- `Hit` out 1: `Addr[31:4] == BASE_ADDR[31:4]`; the system uses it to steer the read mux and gate the data-memory write enable.
- `IRQ` out 1: interrupt request, `irq_pending & CTRL.IM`.

## Operation
- Register map (offset from `BASE_ADDR`):
  - 0x0 `CTRL`, R/W. Bit [0] Enable; bits [2:1] Mode (00 one-shot, 01 auto-reload, 1x treated as one-shot); bit [3] IM. Bits [31:4] read as 0.
  - 0x4 `PRESET`, R/W, 32 bits.
  - 0x8 `COUNT`, read-only; writes are ignored.
  - 0xC reads 0; writes are ignored.
- A write occurs only when `WriteEnable & Hit`. A read of an address that misses the window returns 0.
- A write to `CTRL` also clears `irq_pending`.
- FSM has four states: IDLE, LOAD, CNT, INT.
  - IDLE: if Enable = 1, go to LOAD.
  - LOAD: `COUNT <= PRESET`; go to CNT.
  - CNT:
    - If Enable = 0, go to IDLE; `COUNT` holds its value.
    - Else if `COUNT > 1`, `COUNT <= COUNT - 1`.
    - Else `COUNT <= 0`, set `irq_pending`, go to INT.
  - INT:
    - One-shot: clear Enable, go to IDLE; `irq_pending` stays set until a `CTRL` write.
    - Auto-reload: clear `irq_pending`, go to LOAD.
- A `PRESET` value of 0 behaves as 1.
- A `PRESET` write while counting does not disturb `COUNT`; the new value takes effect at the next LOAD.
- If a CPU write to `CTRL` and an FSM update to Enable happen on the same edge, the CPU write wins.
- If `reset` is asserted mid-count, `COUNT`, `PRESET` and `CTRL` clear at once; `IRQ` drops without waiting for a clock edge.
- `COUNT` decrements without wrap; it never goes below 0.

## Timing
- Reset values: `CTRL`, `PRESET` and `COUNT` = 0; state = IDLE; `irq_pending` = 0; `IRQ` = 0. `ReadData` for any hit = 0.
- `ReadData` has zero-cycle latency, matching single-cycle load semantics. A load of `COUNT` returns the pre-edge value.
- Counting sequence after the Enable write at edge E0:
  - E1: IDLE → LOAD.
  - E2: `COUNT = N`, state CNT.
  - E(N+1): `COUNT = 1`.
  - E(N+2): `COUNT = 0`, state INT, `IRQ` rises if IM = 1.
- Auto-reload: `IRQ` is high for exactly 1 cycle and the period is N+2 cycles.
- One-shot: `IRQ` stays high until a `CTRL` write.

## Configuration
- `TIMER_AUTORELOAD_EN`:
  - Defined: Mode bits are stored and auto-reload operates as described above.
  - Undefined: Mode bits are not stored and read as 0; every expiry behaves as one-shot.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles mid-count with `PRESET` = 10 → all reads return 0, `IRQ` = 0 asynchronously, FSM is IDLE on release.
- One-shot: `PRESET` = 5, `CTRL` = 0x9 → `IRQ` rises after the 7th edge, `COUNT` reads 0, `CTRL` reads 0x8. `IRQ` stays high until a write of `CTRL` = 0x0, then clears on the next edge.
- Auto-reload (macro defined): `PRESET` = 3, `CTRL` = 0xB → `IRQ` is a 1-cycle pulse every 5 cycles; `COUNT` sequence is 3, 2, 1, 0, 0, 3, ...
- Pause: write `CTRL` = 0x0 when `COUNT` = 4 → `COUNT` holds at 4 and there is no `IRQ`. Re-enable → LOAD reloads `PRESET`.
- Decode: store 0xFFFF_FFFF to `BASE_ADDR + 0x8`, and to `BASE_ADDR + 0x10` (which misses, so `Hit` = 0) → `COUNT` is unchanged. A read at `BASE_ADDR + 0xC` returns 0. A read at `BASE_ADDR + 0x1` aliases `CTRL`.
- Masked interrupt: `PRESET` = 0 with IM = 0 → INT is reached 3 edges after enable, `IRQ` stays 0. Writing `CTRL` = 0x8 shows `IRQ` = 0, because the `CTRL` write clears the pending flag.

Source files
------------

// File: rtl/timer_counter.sv
// timer_counter
// Memory-mapped countdown timer sitting on the CPU data-memory bus as a
// responder. Counts clock cycles down from a programmed preset and raises an
// interrupt on expiry, either once (one-shot) or periodically (auto-reload).
//
// Register window (16 bytes at BASE_ADDR, Addr[1:0] ignored):
//   0x0 CTRL   R/W  [0] Enable, [2:1] Mode (01 auto-reload), [3] IM
//   0x4 PRESET R/W  reload value (0 behaves as 1)
//   0x8 COUNT  RO   current count
//   0xC        reads 0, writes ignored
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   Addr        byte address from the CPU
//   WriteEnable store strobe
//   WriteData   store data
//   ReadData    combinational read data (0 on a window miss)
//   Hit         address falls inside the register window
//   IRQ         interrupt request = irq_pending & IM
//
// Build option: TIMER_AUTORELOAD_EN
//   defined   - Mode bits are stored and auto-reload is available
//   undefined - Mode bits read as 0 and every expiry behaves as one-shot
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WriteEnable,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_e;

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic        im_q, im_d;
    logic [1:0]  mode_q;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pend_q, pend_d;

    logic        wr_en;
    logic        autoreload;
    logic        unused_addr;

    assign Hit         = (Addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en       = WriteEnable & Hit;
    assign IRQ         = pend_q & im_q;
    assign autoreload  = (mode_q == 2'b01);
    assign unused_addr = ^Addr[1:0];

`ifdef TIMER_AUTORELOAD_EN
    logic [1:0] mode_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mode_q <= 2'b00;
        else        mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        if (wr_en && Addr[3:2] == 2'd0) mode_d = WriteData[2:1];
    end
`else
    assign mode_q = 2'b00;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;

        case (state_q)
            S_IDLE: begin
                if (en_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                // A zero preset is treated as 1 so expiry still takes a cycle.
                count_d = (preset_q == '0) ? 32'd1 : preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = '0;
                    pend_d  = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                if (autoreload) begin
                    pend_d  = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // CPU stores are applied last so they override same-edge FSM updates.
        if (wr_en) begin
            case (Addr[3:2])
                2'd0: begin
                    en_d   = WriteData[0];
                    im_d   = WriteData[3];
                    pend_d = 1'b0;
                end
                2'd1:    preset_d = WriteData;
                default: ;
            endcase
        end
    end

    always_comb begin
        ReadData = '0;
        if (Hit) begin
            case (Addr[3:2])
                2'd0:    ReadData = {28'd0, im_q, mode_q, en_q};
                2'd1:    ReadData = preset_q;
                2'd2:    ReadData = count_q;
                default: ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

    localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Addr = '0;
    logic        WriteEnable = 1'b0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        Hit;
    logic        IRQ;

    int checks = 0;
    int failures = 0;

    timer_counter #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WriteEnable(WriteEnable),
        .WriteData(WriteData), .ReadData(ReadData), .Hit(Hit), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Timeline model: 'age' is the number of edges since the timer left idle.
    // age 0 -> reload pending, 1..nl -> count = nl-age+1, nl+1 -> expired.
    bit          m_en, m_im, m_pend, m_act;
    bit   [1:0]  m_mode;
    logic [31:0] m_pre, m_cnt;
    longint      m_age, m_nl;

    function automatic bit in_win(logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd16);
    endfunction

    function automatic logic [31:0] m_read(logic [31:0] a);
        if (!in_win(a)) return 32'd0;
        case ((a - BASE) / 4)
            0: return {28'd0, m_im, m_mode, m_en};
            1: return m_pre;
            2: return m_cnt;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_en = 0; m_im = 0; m_pend = 0; m_act = 0; m_mode = 0;
            m_pre = 0; m_cnt = 0; m_age = 0; m_nl = 0;
        end else begin
            if (!m_act) begin
                if (m_en) begin m_act = 1; m_age = 0; end
            end else if (m_age == 0) begin
                m_nl  = (m_pre == 0) ? 1 : m_pre;
                m_cnt = m_nl[31:0];
                m_age = 1;
            end else if (m_age <= m_nl) begin
                if (!m_en) m_act = 0;
                else begin
                    m_age = m_age + 1;
                    m_cnt = (m_age > m_nl) ? 32'd0 : 32'(m_nl - m_age + 1);
                    if (m_age > m_nl) m_pend = 1;
                end
            end else begin
                if (AR && m_mode == 2'b01) begin m_pend = 0; m_age = 0; end
                else begin m_en = 0; m_act = 0; end
            end
            if (WriteEnable && in_win(Addr)) begin
                if (((Addr - BASE) / 4) == 0) begin
                    m_en = WriteData[0];
                    m_im = WriteData[3];
                    if (AR) m_mode = WriteData[2:1];
                    m_pend = 0;
                end else if (((Addr - BASE) / 4) == 1) begin
                    m_pre = WriteData;
                end
            end
        end
    end

    // ---------------- bus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a; WriteData = d; WriteEnable = 1'b1;
        @(posedge clk); #1;
        WriteEnable = 1'b0; Addr = '0; WriteData = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Addr = a; #1; d = ReadData; Addr = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0; step(2); reset = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        // Raise IRQ, then check it drops without a clock edge.
        wr(BASE + 4, 1); wr(BASE, 32'h9); step(3);
        checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL reset_pre_irq got=%b exp=1", IRQ); end
        reset = 1'b0; #1;
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL reset_async_irq got=%b exp=0", IRQ); end
        step(1); reset = 1'b1;
        // Mid-count reset with PRESET=10.
        wr(BASE + 4, 10); wr(BASE, 32'h9); step(4);
        rd(BASE + 8, d);
        checks++; if (d !== 32'd8) begin failures++; $display("FAIL reset_midcount got=%0d exp=8", d); end
        reset = 1'b0; #1;
        rd(BASE, d);
        checks++; if (d !== 0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", d); end
        rd(BASE + 4, d);
        checks++; if (d !== 0) begin failures++; $display("FAIL reset_preset got=%h exp=0", d); end
        rd(BASE + 8, d);
        checks++; if (d !== 0) begin failures++; $display("FAIL reset_count got=%h exp=0", d); end
        step(3); reset = 1'b1; step(3);
        rd(BASE + 8, d);
        checks++; if (d !== 0 || IRQ !== 1'b0) begin failures++; $display("FAIL reset_idle count=%0d irq=%b exp=0/0", d, IRQ); end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        do_reset();
        wr(BASE + 4, 5); wr(BASE, 32'h9);
        for (int e = 1; e <= 7; e++) begin
            step(1);
            checks++;
            if (IRQ !== (e >= 7)) begin failures++; $display("FAIL oneshot_irq edge=%0d got=%b exp=%b", e, IRQ, e >= 7); end
            if (e == 2) begin
                rd(BASE + 8, d);
                checks++; if (d !== 32'd5) begin failures++; $display("FAIL oneshot_load got=%0d exp=5", d); end
            end
        end
        rd(BASE + 8, d);
        checks++; if (d !== 0) begin failures++; $display("FAIL oneshot_count got=%0d exp=0", d); end
        step(4);
        rd(BASE, d);
        checks++; if (d !== 32'h8 || IRQ !== 1'b1) begin failures++; $display("FAIL oneshot_hold ctrl=%h irq=%b exp=8/1", d, IRQ); end
        wr(BASE, 32'h0);
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL oneshot_clear got=%b exp=0", IRQ); end
    endtask

    task automatic test_autoreload();
        logic [31:0] d;
        int seq[5] = '{3, 2, 1, 0, 0};
        do_reset();
        wr(BASE + 4, 3); wr(BASE, 32'hB);
`ifdef TIMER_AUTORELOAD_EN
        for (int e = 1; e <= 13; e++) begin
            step(1);
            rd(BASE + 8, d);
            checks++;
            if (e >= 2) begin
                if (d !== 32'(seq[(e - 2) % 5]) || IRQ !== ((e - 2) % 5 == 3)) begin
                    failures++;
                    $display("FAIL autoreload edge=%0d count=%0d irq=%b exp=%0d/%b", e, d, IRQ, seq[(e - 2) % 5], (e - 2) % 5 == 3);
                end
            end else if (d !== 0 || IRQ !== 1'b0) begin
                failures++; $display("FAIL autoreload_first count=%0d irq=%b exp=0/0", d, IRQ);
            end
        end
`else
        rd(BASE, d);
        checks++; if (d !== 32'h9) begin failures++; $display("FAIL nomode_ctrl got=%h exp=9", d); end
        step(5);
        checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL nomode_irq got=%b exp=1", IRQ); end
        step(6);
        rd(BASE, d);
        checks++; if (IRQ !== 1'b1 || d !== 32'h8) begin failures++; $display("FAIL nomode_oneshot irq=%b ctrl=%h exp=1/8", IRQ, d); end
        if (seq[0] != 3) ;
`endif
    endtask

    task automatic test_pause();
        logic [31:0] d;
        do_reset();
        wr(BASE + 4, 6); wr(BASE, 32'h9);
        step(3);
        wr(BASE, 32'h0);  // edge where COUNT becomes 4
        rd(BASE + 8, d);
        checks++; if (d !== 32'd4) begin failures++; $display("FAIL pause_at got=%0d exp=4", d); end
        step(6);
        rd(BASE + 8, d);
        checks++; if (d !== 32'd4 || IRQ !== 1'b0) begin failures++; $display("FAIL pause_hold count=%0d irq=%b exp=4/0", d, IRQ); end
        wr(BASE + 4, 2);
        rd(BASE + 8, d);
        checks++; if (d !== 32'd4) begin failures++; $display("FAIL pause_preset_wr got=%0d exp=4", d); end
        wr(BASE, 32'h9); step(2);
        rd(BASE + 8, d);
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL pause_reload got=%0d exp=2", d); end
        step(2);
        checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL pause_expire got=%b exp=1", IRQ); end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        do_reset();
        wr(BASE + 4, 7); wr(BASE, 32'h1); step(2);
        wr(BASE, 32'h0);  // COUNT moves 7 -> 6 and then holds
        Addr = BASE + 8; #1;
        checks++; if (Hit !== 1'b1) begin failures++; $display("FAIL decode_hit got=%b exp=1", Hit); end
        wr(BASE + 8, 32'hFFFF_FFFF);
        Addr = BASE + 32'h10; #1;
        checks++; if (Hit !== 1'b0) begin failures++; $display("FAIL decode_miss_hit got=%b exp=0", Hit); end
        wr(BASE + 32'h10, 32'hFFFF_FFFF);
        rd(BASE + 8, d);
        checks++; if (d !== 32'd6) begin failures++; $display("FAIL decode_count got=%0d exp=6", d); end
        rd(BASE, d);
        checks++; if (d !== 0) begin failures++; $display("FAIL decode_ctrl_miss got=%h exp=0", d); end
        rd(BASE + 32'hC, d);
        checks++; if (d !== 0) begin failures++; $display("FAIL decode_rsvd got=%h exp=0", d); end
        rd(BASE + 32'h14, d);
        checks++; if (d !== 0) begin failures++; $display("FAIL decode_miss_rd got=%h exp=0", d); end
        wr(BASE, 32'h8);
        rd(BASE + 1, d);
        checks++; if (d !== 32'h8) begin failures++; $display("FAIL decode_alias got=%h exp=8", d); end
    endtask

    task automatic test_masked();
        logic [31:0] d;
        do_reset();
        wr(BASE + 4, 0); wr(BASE, 32'h1);
        step(2);
        rd(BASE + 8, d);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL masked_load got=%0d exp=1", d); end
        step(1);
        rd(BASE, d);
        checks++; if (IRQ !== 1'b0 || d !== 32'h1) begin failures++; $display("FAIL masked_int irq=%b ctrl=%h exp=0/1", IRQ, d); end
        step(1);
        rd(BASE, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL masked_idle ctrl=%h exp=0", d); end
        wr(BASE, 32'h8);
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL masked_im got=%b exp=0", IRQ); end
    endtask

    task automatic test_random();
        int op;
        logic [31:0] exp_rd;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 9);
            WriteEnable = 1'b0; WriteData = $urandom;
            case (op)
                0, 1: begin Addr = BASE; WriteData = $urandom_range(0, 15); WriteEnable = 1'b1; end
                2:    begin Addr = BASE + 4; WriteData = $urandom_range(0, 5); WriteEnable = 1'b1; end
                3:    begin Addr = BASE + 8 + $urandom_range(0, 7); WriteEnable = 1'b1; end
                4:    begin Addr = BASE + 16 + $urandom_range(0, 15); WriteEnable = 1'b1; end
                default: Addr = BASE + $urandom_range(0, 19);
            endcase
            if (op == 0 && $urandom_range(0, 1) == 1) WriteData = WriteData | 32'h1;
            #1;
            exp_rd = m_read(Addr);
            checks++;
            if (ReadData !== exp_rd || IRQ !== (m_pend & m_im)) begin
                failures++;
                $display("FAIL random i=%0d addr=%h rd=%h irq=%b exp=%h/%b", i, Addr, ReadData, IRQ, exp_rd, m_pend & m_im);
            end
            step(1);
        end
        WriteEnable = 1'b0; Addr = '0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_pause();
        test_decode();
        test_masked();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
